// File: rtl/ms_stopwatch_pkg.sv
// rtl/ms_stopwatch_pkg.sv - shared types and BCD limits for the millisecond stopwatch
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSED,
        ST_FULL
    } state_e;

    typedef struct packed {
        logic [7:0]  min;
        logic [7:0]  sec;
        logic [11:0] ms;
    } time_bcd_t;

    localparam int         MIN_MAX_DEFAULT = 99;
    localparam logic [3:0] MS_DIGIT_MAX    = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX    = 4'd5;

    // Highest representable time, MIN_MAX:59.999, in display order.
    function automatic time_bcd_t sat_value(int min_max);
        time_bcd_t t;
        t.min = {4'(min_max / 10), 4'(min_max % 10)};
        t.sec = {SEC_TENS_MAX, MS_DIGIT_MAX};
        t.ms  = {MS_DIGIT_MAX, MS_DIGIT_MAX, MS_DIGIT_MAX};
        return t;
    endfunction

endpackage

// File: rtl/ms_stopwatch_if.sv
// rtl/ms_stopwatch_if.sv - control pulses in, BCD display and status out
interface ms_stopwatch_if;
    logic        tick_ms;
    logic        start;
    logic        stop;
    logic        clear;
    logic        lap;
    logic [11:0] ms_bcd;
    logic [7:0]  sec_bcd;
    logic [7:0]  min_bcd;
    logic        running;
    logic        lap_hold;
    logic        overflow;

    modport master (
        output tick_ms, start, stop, clear, lap,
        input  ms_bcd, sec_bcd, min_bcd, running, lap_hold, overflow
    );

    modport slave (
        input  tick_ms, start, stop, clear, lap,
        output ms_bcd, sec_bcd, min_bcd, running, lap_hold, overflow
    );
endinterface

// File: rtl/ms_stopwatch_bcd_digit.sv
// rtl/ms_stopwatch_bcd_digit.sv - one BCD digit wrapping at LIMIT, with carry out
module bcd_digit #(
    parameter logic [3:0] LIMIT = 4'd9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] digit,
    output logic       carry_out
);

    logic [3:0] digit_q;
    logic [3:0] digit_d;

    always_comb begin
        digit_d = digit_q;
        if (clr) begin
            digit_d = 4'd0;
        end else if (inc) begin
            digit_d = (digit_q == LIMIT) ? 4'd0 : digit_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit     = digit_q;
    assign carry_out = inc && (digit_q == LIMIT);

endmodule

// File: rtl/ms_stopwatch.sv
// rtl/ms_stopwatch.sv - BCD min:sec.ms stopwatch driven by a 1 ms strobe
module ms_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int MIN_MAX = MIN_MAX_DEFAULT
) (
    input logic          clk,
    input logic          rst,
    ms_stopwatch_if.slave sw
);

    localparam time_bcd_t SAT = sat_value(MIN_MAX);

    state_e    state_q, state_d;
    logic      lap_hold_q, lap_hold_d;
    logic      overflow_q, overflow_d;
    time_bcd_t snap_q, snap_d;
    time_bcd_t live;
    time_bcd_t disp;
    logic      at_sat;
    logic      count_en;
    logic      sat_hit;
    logic [6:0] carry;

    assign at_sat   = (live == SAT);
    assign count_en = (state_q == ST_RUN) && sw.tick_ms && !at_sat;
    // A carry out of the top digit can only mean the range was exceeded; treat it as saturation.
    assign sat_hit  = ((state_q == ST_RUN) && sw.tick_ms && at_sat) || carry[6];

    bcd_digit #(.LIMIT(MS_DIGIT_MAX)) u_ms_ones (
        .clk(clk), .rst(rst), .clr(sw.clear), .inc(count_en),
        .digit(live.ms[3:0]), .carry_out(carry[0]));
    bcd_digit #(.LIMIT(MS_DIGIT_MAX)) u_ms_tens (
        .clk(clk), .rst(rst), .clr(sw.clear), .inc(carry[0]),
        .digit(live.ms[7:4]), .carry_out(carry[1]));
    bcd_digit #(.LIMIT(MS_DIGIT_MAX)) u_ms_hund (
        .clk(clk), .rst(rst), .clr(sw.clear), .inc(carry[1]),
        .digit(live.ms[11:8]), .carry_out(carry[2]));
    bcd_digit #(.LIMIT(MS_DIGIT_MAX)) u_sec_ones (
        .clk(clk), .rst(rst), .clr(sw.clear), .inc(carry[2]),
        .digit(live.sec[3:0]), .carry_out(carry[3]));
    bcd_digit #(.LIMIT(SEC_TENS_MAX)) u_sec_tens (
        .clk(clk), .rst(rst), .clr(sw.clear), .inc(carry[3]),
        .digit(live.sec[7:4]), .carry_out(carry[4]));
    bcd_digit #(.LIMIT(MS_DIGIT_MAX)) u_min_ones (
        .clk(clk), .rst(rst), .clr(sw.clear), .inc(carry[4]),
        .digit(live.min[3:0]), .carry_out(carry[5]));
    bcd_digit #(.LIMIT(MS_DIGIT_MAX)) u_min_tens (
        .clk(clk), .rst(rst), .clr(sw.clear), .inc(carry[5]),
        .digit(live.min[7:4]), .carry_out(carry[6]));

    always_comb begin
        state_d    = state_q;
        lap_hold_d = lap_hold_q;
        overflow_d = overflow_q;
        snap_d     = snap_q;

        case (state_q)
            ST_IDLE:   if (sw.start) state_d = ST_RUN;
            ST_RUN: begin
                if (sat_hit) begin
                    state_d = ST_FULL;
                end else if (sw.stop) begin
                    state_d = ST_PAUSED;
                end
            end
            ST_PAUSED: if (sw.start) state_d = ST_RUN;
            default:   state_d = state_q;
        endcase

        if (sat_hit) begin
            overflow_d = 1'b1;
        end

        // Snapshot samples the registered count, i.e. before any same-cycle tick.
        if (sw.lap) begin
            if (lap_hold_q) begin
                lap_hold_d = 1'b0;
            end else begin
                lap_hold_d = 1'b1;
                snap_d     = live;
            end
        end

        if (sw.clear) begin
            state_d    = ST_IDLE;
            lap_hold_d = 1'b0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            lap_hold_q <= 1'b0;
            overflow_q <= 1'b0;
            snap_q     <= '0;
        end else begin
            state_q    <= state_d;
            lap_hold_q <= lap_hold_d;
            overflow_q <= overflow_d;
            snap_q     <= snap_d;
        end
    end

    assign disp        = lap_hold_q ? snap_q : live;
    assign sw.ms_bcd   = disp.ms;
    assign sw.sec_bcd  = disp.sec;
    assign sw.min_bcd  = disp.min;
    assign sw.running  = (state_q == ST_RUN);
    assign sw.lap_hold = lap_hold_q;
    assign sw.overflow = overflow_q;

endmodule

// File: tb/tb_ms_stopwatch.sv
// tb/tb_ms_stopwatch.sv - directed bench; unit B (MIN_MAX=0) mirrors unit A's inputs to reach saturation
module tb_ms_stopwatch;

    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    ms_stopwatch_if sw_a ();
    ms_stopwatch_if sw_b ();

    assign sw_b.tick_ms = sw_a.tick_ms;
    assign sw_b.start   = sw_a.start;
    assign sw_b.stop    = sw_a.stop;
    assign sw_b.clear   = sw_a.clear;
    assign sw_b.lap     = sw_a.lap;

    ms_stopwatch #(.MIN_MAX(99)) u_a (.clk(clk), .rst(rst), .sw(sw_a));
    ms_stopwatch #(.MIN_MAX(0))  u_b (.clk(clk), .rst(rst), .sw(sw_b));

    function automatic logic [31:0] disp_a();
        return {4'h0, sw_a.min_bcd, sw_a.sec_bcd, sw_a.ms_bcd};
    endfunction

    function automatic logic [31:0] disp_b();
        return {4'h0, sw_b.min_bcd, sw_b.sec_bcd, sw_b.ms_bcd};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            sw_a.tick_ms = 1'b1;
            step();
            sw_a.tick_ms = 1'b0;
            repeat (gap - 1) step();
        end
    endtask

    initial begin
        rst          = 1'b1;
        sw_a.tick_ms = 1'b0;
        sw_a.start   = 1'b0;
        sw_a.stop    = 1'b0;
        sw_a.clear   = 1'b0;
        sw_a.lap     = 1'b0;
        step();
        step();
        chk("rst_disp", disp_a(), 32'h0);
        chk("rst_running", {31'd0, sw_a.running}, 32'd0);
        chk("rst_lap_hold", {31'd0, sw_a.lap_hold}, 32'd0);
        chk("rst_overflow", {31'd0, sw_a.overflow}, 32'd0);
        rst = 1'b0;

        // Tick before start is ignored
        sw_a.tick_ms = 1'b1; step(); sw_a.tick_ms = 1'b0;
        chk("idle_tick", disp_a(), 32'h0);

        sw_a.start = 1'b1; step(); sw_a.start = 1'b0;
        chk("start_running", {31'd0, sw_a.running}, 32'd1);

        tick_n(1500, 5);
        chk("count_1500", disp_a(), 32'h0001500);
        chk("count_running", {31'd0, sw_a.running}, 32'd1);

        sw_a.stop = 1'b1; step(); sw_a.stop = 1'b0;
        chk("stop_running", {31'd0, sw_a.running}, 32'd0);
        tick_n(20, 5);
        chk("paused_hold", disp_a(), 32'h0001500);

        sw_a.start = 1'b1; step(); sw_a.start = 1'b0;
        tick_n(500, 1);
        chk("resume_2000", disp_a(), 32'h0002000);

        sw_a.lap = 1'b1; step(); sw_a.lap = 1'b0;
        chk("lap_set", {31'd0, sw_a.lap_hold}, 32'd1);
        tick_n(300, 1);
        chk("lap_frozen", disp_a(), 32'h0002000);
        chk("lap_hold_kept", {31'd0, sw_a.lap_hold}, 32'd1);
        sw_a.lap = 1'b1; step(); sw_a.lap = 1'b0;
        chk("lap_release", disp_a(), 32'h0002300);
        chk("lap_clear", {31'd0, sw_a.lap_hold}, 32'd0);

        tick_n(57699, 1);
        chk("pre_carry_a", disp_a(), 32'h0059999);
        chk("pre_sat_b", disp_b(), 32'h0059999);
        chk("pre_sat_ovf_b", {31'd0, sw_b.overflow}, 32'd0);

        sw_a.tick_ms = 1'b1; step(); sw_a.tick_ms = 1'b0;
        chk("carry_chain_a", disp_a(), 32'h0100000);
        chk("sat_hold_b", disp_b(), 32'h0059999);
        chk("sat_ovf_b", {31'd0, sw_b.overflow}, 32'd1);
        chk("sat_running_b", {31'd0, sw_b.running}, 32'd0);
        chk("no_ovf_a", {31'd0, sw_a.overflow}, 32'd0);

        sw_a.start = 1'b1; step(); sw_a.start = 1'b0;
        chk("full_start_b", {31'd0, sw_b.running}, 32'd0);
        chk("run_start_a", {31'd0, sw_a.running}, 32'd1);
        tick_n(1, 1);
        chk("full_tick_b", disp_b(), 32'h0059999);
        chk("run_tick_a", disp_a(), 32'h0100001);

        sw_a.clear = 1'b1; step(); sw_a.clear = 1'b0;
        chk("clear_a", disp_a(), 32'h0);
        chk("clear_b", disp_b(), 32'h0);
        chk("clear_ovf_b", {31'd0, sw_b.overflow}, 32'd0);
        chk("clear_running_a", {31'd0, sw_a.running}, 32'd0);

        sw_a.start = 1'b1; step(); sw_a.start = 1'b0;
        tick_n(5, 1);
        chk("simul_base", disp_a(), 32'h0000005);
        sw_a.stop = 1'b1; sw_a.tick_ms = 1'b1; step(); sw_a.stop = 1'b0; sw_a.tick_ms = 1'b0;
        chk("stop_tick_cnt", disp_a(), 32'h0000006);
        chk("stop_tick_run", {31'd0, sw_a.running}, 32'd0);
        sw_a.start = 1'b1; sw_a.tick_ms = 1'b1; step(); sw_a.start = 1'b0; sw_a.tick_ms = 1'b0;
        chk("start_tick_cnt", disp_a(), 32'h0000006);
        chk("start_tick_run", {31'd0, sw_a.running}, 32'd1);
        tick_n(1, 1);
        chk("after_start_tick", disp_a(), 32'h0000007);
        sw_a.clear = 1'b1; sw_a.start = 1'b1; sw_a.tick_ms = 1'b1; step();
        sw_a.clear = 1'b0; sw_a.start = 1'b0; sw_a.tick_ms = 1'b0;
        chk("clr_start_tick", disp_a(), 32'h0);
        chk("clr_start_run", {31'd0, sw_a.running}, 32'd0);

        sw_a.start = 1'b1; step(); sw_a.start = 1'b0;
        tick_n(750, 1);
        chk("mid_750", disp_a(), 32'h0000750);
        sw_a.lap = 1'b1; step(); sw_a.lap = 1'b0;
        chk("mid_lap", {31'd0, sw_a.lap_hold}, 32'd1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("midrst_disp", disp_a(), 32'h0);
        chk("midrst_lap", {31'd0, sw_a.lap_hold}, 32'd0);
        chk("midrst_run", {31'd0, sw_a.running}, 32'd0);
        tick_n(1, 1);
        chk("midrst_tick", disp_a(), 32'h0);
        sw_a.start = 1'b1; step(); sw_a.start = 1'b0;
        tick_n(1, 1);
        chk("restart_tick", disp_a(), 32'h0000001);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
